// File: rtl/fp_addsub_issue_ctrl.sv
// rtl/fp_addsub_issue_ctrl.sv - credit-gated issue/capture front end for a fixed-latency FP add/sub unit
// Optional sticky flag accumulation: FP_ADDSUB_ISSUE_STICKY_FLAGS_EN
module fp_addsub_issue_ctrl #(
    parameter int FPU_LATENCY = 11,
    parameter int FIFO_DEPTH  = 16,
    parameter int TAG_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_a,
    input  logic [31:0]                   in_b,
    input  logic                          in_op,
    input  logic [TAG_W-1:0]              in_tag,
    output logic [31:0]                   fpu_a,
    output logic [31:0]                   fpu_b,
    output logic                          fpu_ctrl,
    input  logic [31:0]                   fpu_z,
    input  logic [4:0]                    fpu_flags,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_z,
    output logic [4:0]                    out_flags,
    output logic [TAG_W-1:0]              out_tag,
    output logic [$clog2(FIFO_DEPTH):0]   inflight,
    output logic [4:0]                    sticky_flags,
    input  logic                          flags_clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 32 + 5 + TAG_W;
    localparam logic [CW:0]   L_DEPTH = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] L_ONE   = CW'(1);
    localparam logic [PW-1:0] L_PONE  = PW'(1);

    logic [31:0]             r_fpu_a;
    logic [31:0]             r_fpu_b;
    logic                    r_fpu_ctrl;
    logic [FPU_LATENCY:0]    r_dl_vld;
    logic [TAG_W-1:0]        r_dl_tag [FPU_LATENCY+1];
    logic [EW-1:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           r_inflight;

    logic [CW:0]             w_used;
    logic                    w_issue;
    logic                    w_cap;
    logic                    w_pop;

    // Every issued op reserves a FIFO slot, so the unstallable FPU can never overrun it
    assign w_used   = {1'b0, r_inflight} + {1'b0, r_count};
    assign in_ready = !rst && (w_used < L_DEPTH);
    assign w_issue  = in_valid && in_ready;
    assign w_cap    = r_dl_vld[FPU_LATENCY];
    assign w_pop    = out_valid && out_ready;

    assign fpu_a     = r_fpu_a;
    assign fpu_b     = r_fpu_b;
    assign fpu_ctrl  = r_fpu_ctrl;
    assign out_valid = (r_count != '0);
    assign {out_z, out_flags, out_tag} = r_mem[r_rptr];
    assign inflight  = r_inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpu_a    <= '0;
            r_fpu_b    <= '0;
            r_fpu_ctrl <= 1'b0;
            r_dl_vld   <= '0;
        end else begin
            r_fpu_a    <= w_issue ? in_a  : 32'd0;
            r_fpu_b    <= w_issue ? in_b  : 32'd0;
            r_fpu_ctrl <= w_issue ? in_op : 1'b0;
            r_dl_vld   <= {r_dl_vld[FPU_LATENCY-1:0], w_issue};
        end
    end

    // Tags are only meaningful alongside their valid bit, so they need no reset
    always_ff @(posedge clk) begin
        r_dl_tag[0] <= in_tag;
        for (int i = 1; i <= FPU_LATENCY; i++) begin
            r_dl_tag[i] <= r_dl_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_cap) begin
                r_mem[r_wptr] <= {fpu_z, fpu_flags, r_dl_tag[FPU_LATENCY]};
                r_wptr        <= r_wptr + L_PONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_PONE;
            end
            case ({w_cap, w_pop})
                2'b10:   r_count <= r_count + L_ONE;
                2'b01:   r_count <= r_count - L_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_cap})
                2'b10:   r_inflight <= r_inflight + L_ONE;
                2'b01:   r_inflight <= r_inflight - L_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_used <= L_DEPTH);
        end
    end

`ifdef FP_ADDSUB_ISSUE_STICKY_FLAGS_EN
    logic [4:0] r_sticky;

    // A clear in the same cycle as a pop discards the popped flags
    always_ff @(posedge clk) begin
        if (rst || flags_clr) begin
            r_sticky <= '0;
        end else if (w_pop) begin
            r_sticky <= r_sticky | out_flags;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr = flags_clr;
    assign sticky_flags = '0;
`endif

endmodule
